ram_port_arbiter: RTL and testbench

//  Shares the main semi-dual-port BSRAM (write port A, read port B) between two requesters:
//  m0 = CPU, m1 = loader/DMA engine. One access granted per cycle, round-robin fairness,

---
 rtl/ram_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the main semi-dual-port BSRAM (port A write, port B read) between
//   two requesters: m0 (CPU) and m1 (loader/DMA). At most one access is
//   accepted per cycle. Ties are broken round-robin, a requester may hold the
//   bus for a bounded burst with mN_lock, and read data is steered back to the
//   requester that issued the read.
//
// Parameters
//   ADDR_W    RAM word address width
//   DATA_W    RAM data width
//   READ_LAT  read-accept edge to valid dout, in cycles (1 or 2)
//   LOCK_MAX  max consecutive locked grants before a forced hand-over (>= 1)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   mN_req/we/lock          request, write(1)/read(0), keep grant for burst
//   mN_addr/wdata           access address and write data
//   mN_gnt                  combinational accept (with mN_req)
//   mN_rvalid/rdata         one-cycle read response pulse and its data
//   cea/ada/din             RAM write port
//   ceb/adb                 RAM read port
//   oce                     RAM output-register enable, tied high
//   dout                    RAM read data
module ram_port_arbiter #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              cea,
   output logic [ADDR_W-1:0] ada,
   output logic [DATA_W-1:0] din,
   output logic              ceb,
   output logic [ADDR_W-1:0] adb,
   output logic              oce,
   input  logic [DATA_W-1:0] dout
);

   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

   // registered arbitration state
   master_e           rr_last_q,  rr_last_d;
   logic              lock_act_q, lock_act_d;
   master_e           lock_id_q,  lock_id_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

   // per-requester read-response pipes; bit 0 is loaded at the accept edge
   logic [READ_LAT-1:0] rv0_q, rv0_d;
   logic [READ_LAT-1:0] rv1_q, rv1_d;

   logic              req0, req1, own_req, acc;
   master_e           win;
   logic              sel_we, sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [CNT_W-1:0]  cnt_inc;

   // ------------------------------------------------------------------
   // Arbitration. Requests are masked by rst_n so every grant and RAM
   // strobe drops to zero as soon as reset asserts.
   // ------------------------------------------------------------------
   always_comb begin
      req0    = m0_req & rst_n;
      req1    = m1_req & rst_n;
      own_req = (lock_id_q == M1) ? req1 : req0;
      acc     = req0 | req1;
      win     = M0;
      if (lock_act_q && own_req) begin
         win = lock_id_q;
      end else if (req1 && !req0) begin
         win = M1;
      end else if (req0 && req1) begin
         win = (rr_last_q == M0) ? M1 : M0;
      end
   end

   // winner's request fields
   always_comb begin
      if (win == M1) begin
         sel_we    = m1_we;
         sel_lock  = m1_lock;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
      end else begin
         sel_we    = m0_we;
         sel_lock  = m0_lock;
         sel_addr  = m0_addr;
         sel_wdata = m0_wdata;
      end
   end

   // grants and RAM strobes; idle address/data buses are held at zero
   always_comb begin
      m0_gnt = acc && (win == M0);
      m1_gnt = acc && (win == M1);
      cea    = acc &  sel_we;
      ceb    = acc & ~sel_we;
      ada    = cea ? sel_addr  : '0;
      din    = cea ? sel_wdata : '0;
      adb    = ceb ? sel_addr  : '0;
      oce    = 1'b1;
   end

   // ------------------------------------------------------------------
   // Next state: round-robin pointer, lock tracking, response pipes
   // ------------------------------------------------------------------
   always_comb begin
      rr_last_d  = acc ? win : rr_last_q;
      lock_act_d = lock_act_q;
      lock_id_d  = lock_id_q;
      lock_cnt_d = lock_cnt_q;

      // a lock grant continues the current run only for the same owner
      cnt_inc = (lock_act_q && (lock_id_q == win)) ? lock_cnt_q + CNT_W'(1)
                                                  : CNT_W'(1);
      if (acc) begin
         if (sel_lock && (cnt_inc != CNT_W'(LOCK_MAX))) begin
            lock_act_d = 1'b1;
            lock_id_d  = win;
            lock_cnt_d = cnt_inc;
         end else begin
            // unlocked access, or the run just hit LOCK_MAX
            lock_act_d = 1'b0;
            lock_cnt_d = '0;
         end
      end else begin
         // nobody requesting, so the owner has dropped its request
         lock_act_d = 1'b0;
         lock_cnt_d = '0;
      end

      // shift toward the MSB; the top bit is the registered rvalid
      rv0_d = READ_LAT'({rv0_q, ceb & (win == M0)});
      rv1_d = READ_LAT'({rv1_q, ceb & (win == M1)});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q  <= M1;
         lock_act_q <= 1'b0;
         lock_id_q  <= M0;
         lock_cnt_q <= '0;
         rv0_q      <= '0;
         rv1_q      <= '0;
      end else begin
         rr_last_q  <= rr_last_d;
         lock_act_q <= lock_act_d;
         lock_id_q  <= lock_id_d;
         lock_cnt_q <= lock_cnt_d;
         rv0_q      <= rv0_d;
         rv1_q      <= rv1_d;
      end
   end

   // read return
   always_comb begin
      m0_rvalid = rv0_q[READ_LAT-1];
      m1_rvalid = rv1_q[READ_LAT-1];
      m0_rdata  = m0_rvalid ? dout : '0;
      m1_rdata  = m1_rvalid ? dout : '0;
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Two instances share one stimulus:
// dut_a with READ_LAT=1 and dut_b with READ_LAT=2, each with its own RAM model.
module tb_ram_port_arbiter;

   localparam int AW = 13;
   localparam int DW = 8;

   logic          clk, rst_n;
   logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;

   logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
   logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_din, dout_a;
   logic          a_cea, a_ceb, a_oce;
   logic [AW-1:0] a_ada, a_adb;

   logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
   logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_din, dout_b, pipe_b;
   logic          b_cea, b_ceb, b_oce;
   logic [AW-1:0] b_ada, b_adb;

   logic [DW-1:0] mem_a [0:8191];
   logic [DW-1:0] mem_b [0:8191];

   int total = 0;
   int bad   = 0;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .LOCK_MAX(16)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
      .cea(a_cea), .ada(a_ada), .din(a_din), .ceb(a_ceb), .adb(a_adb), .oce(a_oce), .dout(dout_a)
   );

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .LOCK_MAX(16)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .cea(b_cea), .ada(b_ada), .din(b_din), .ceb(b_ceb), .adb(b_adb), .oce(b_oce), .dout(dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: bypass mode for dut_a, output register (oce=1) for dut_b
   always @(posedge clk) begin
      if (a_cea) mem_a[a_ada] <= a_din;
      if (a_ceb) dout_a <= mem_a[a_adb];
   end

   always @(posedge clk) begin
      if (b_cea) mem_b[b_ada] <= b_din;
      if (b_ceb) pipe_b <= mem_b[b_adb];
      dout_b <= pipe_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_gnt(input string tag, input logic g0, input logic g1);
      chk({tag, ".a_gnt0"}, 32'(a_m0_gnt), 32'(g0));
      chk({tag, ".a_gnt1"}, 32'(a_m1_gnt), 32'(g1));
      chk({tag, ".b_gnt0"}, 32'(b_m0_gnt), 32'(g0));
      chk({tag, ".b_gnt1"}, 32'(b_m1_gnt), 32'(g1));
   endtask

   task automatic chk_ram(input string tag, input logic ce_a, input logic [AW-1:0] ad_a,
                          input logic [DW-1:0] d, input logic ce_b, input logic [AW-1:0] ad_b);
      chk({tag, ".a_cea"}, 32'(a_cea), 32'(ce_a));
      chk({tag, ".a_ada"}, 32'(a_ada), 32'(ad_a));
      chk({tag, ".a_din"}, 32'(a_din), 32'(d));
      chk({tag, ".a_ceb"}, 32'(a_ceb), 32'(ce_b));
      chk({tag, ".a_adb"}, 32'(a_adb), 32'(ad_b));
      chk({tag, ".b_cea"}, 32'(b_cea), 32'(ce_a));
      chk({tag, ".b_ada"}, 32'(b_ada), 32'(ad_a));
      chk({tag, ".b_din"}, 32'(b_din), 32'(d));
      chk({tag, ".b_ceb"}, 32'(b_ceb), 32'(ce_b));
      chk({tag, ".b_adb"}, 32'(b_adb), 32'(ad_b));
   endtask

   // sel_b=0 checks dut_a, sel_b=1 checks dut_b; rdata checked only when valid
   task automatic chk_rv(input string tag, input logic sel_b, input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1);
      logic          ov0, ov1;
      logic [DW-1:0] od0, od1;
      string         nm;
      ov0 = sel_b ? b_m0_rvalid : a_m0_rvalid;
      ov1 = sel_b ? b_m1_rvalid : a_m1_rvalid;
      od0 = sel_b ? b_m0_rdata  : a_m0_rdata;
      od1 = sel_b ? b_m1_rdata  : a_m1_rdata;
      nm  = sel_b ? ".b" : ".a";
      chk({tag, nm, "_rv0"}, 32'(ov0), 32'(v0));
      if (v0) chk({tag, nm, "_rd0"}, 32'(od0), 32'(d0));
      chk({tag, nm, "_rv1"}, 32'(ov1), 32'(v1));
      if (v1) chk({tag, nm, "_rd1"}, 32'(od1), 32'(d1));
   endtask

   task automatic chk_reset(input string tag);
      chk_gnt(tag, 1'b0, 1'b0);
      chk_ram(tag, 1'b0, '0, '0, 1'b0, '0);
      chk_rv(tag, 1'b0, 1'b0, '0, 1'b0, '0);
      chk_rv(tag, 1'b1, 1'b0, '0, 1'b0, '0);
      chk({tag, ".a_oce"}, 32'(a_oce), 32'd1);
      chk({tag, ".b_oce"}, 32'(b_oce), 32'd1);
   endtask

   task automatic drv0(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
   endtask

   task automatic drv1(input logic r, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
      m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
   endtask

   // inputs change 1 ns after the rising edge, outputs are checked on the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drv0(0, 0, 0, '0, '0);
      drv1(0, 0, 0, '0, '0);
      #2;
      chk_reset("reset");
      tick();
      tick();
      rst_n = 1'b1;

      // 1: m0 write 0x0123 <- 0xA5, then read it back
      drv0(1, 1, 0, 13'h0123, 8'hA5);
      mid(); chk_gnt("t1.wr", 1, 0); chk_ram("t1.wr", 1, 13'h0123, 8'hA5, 0, '0);
      tick();
      drv0(1, 0, 0, 13'h0123, 8'h00);
      mid(); chk_gnt("t1.rd", 1, 0); chk_ram("t1.rd", 0, '0, '0, 1, 13'h0123);
      chk_rv("t1.rd", 0, 0, '0, 0, '0); chk_rv("t1.rd", 1, 0, '0, 0, '0);
      tick();
      drv0(0, 0, 0, '0, '0);
      mid(); chk_gnt("t1.c2", 0, 0); chk_ram("t1.c2", 0, '0, '0, 0, '0);
      chk_rv("t1.c2", 0, 1, 8'hA5, 0, '0); chk_rv("t1.c2", 1, 0, '0, 0, '0);
      tick();
      mid(); chk_rv("t1.c3", 0, 0, '0, 0, '0); chk_rv("t1.c3", 1, 1, 8'hA5, 0, '0);
      tick();
      mid(); chk_rv("t1.c4", 1, 0, '0, 0, '0);
      tick();

      // 2: m1 preloads four words, reset, then both read every cycle
      drv1(1, 1, 0, 13'h0010, 8'h3C); mid(); chk_gnt("t2.w0", 0, 1); chk_ram("t2.w0", 1, 13'h0010, 8'h3C, 0, '0); tick();
      drv1(1, 1, 0, 13'h0011, 8'hC3); mid(); chk_gnt("t2.w1", 0, 1); tick();
      drv1(1, 1, 0, 13'h0020, 8'h5A); mid(); chk_gnt("t2.w2", 0, 1); tick();
      drv1(1, 1, 0, 13'h0021, 8'h96); mid(); chk_gnt("t2.w3", 0, 1); tick();
      drv1(0, 0, 0, '0, '0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drv0(1, 0, 0, 13'h0010, '0); drv1(1, 0, 0, 13'h0020, '0);
      mid(); chk_gnt("t2.k0", 1, 0); chk_ram("t2.k0", 0, '0, '0, 1, 13'h0010);
      tick();
      drv0(1, 0, 0, 13'h0011, '0);
      mid(); chk_gnt("t2.k1", 0, 1); chk_ram("t2.k1", 0, '0, '0, 1, 13'h0020);
      chk_rv("t2.k1", 0, 1, 8'h3C, 0, '0); chk_rv("t2.k1", 1, 0, '0, 0, '0);
      tick();
      drv1(1, 0, 0, 13'h0021, '0);
      mid(); chk_gnt("t2.k2", 1, 0); chk_ram("t2.k2", 0, '0, '0, 1, 13'h0011);
      chk_rv("t2.k2", 0, 0, '0, 1, 8'h5A); chk_rv("t2.k2", 1, 1, 8'h3C, 0, '0);
      tick();
      drv0(0, 0, 0, '0, '0);
      mid(); chk_gnt("t2.k3", 0, 1); chk_ram("t2.k3", 0, '0, '0, 1, 13'h0021);
      chk_rv("t2.k3", 0, 1, 8'hC3, 0, '0); chk_rv("t2.k3", 1, 0, '0, 1, 8'h5A);
      tick();
      drv1(0, 0, 0, '0, '0);
      mid(); chk_gnt("t2.k4", 0, 0);
      chk_rv("t2.k4", 0, 0, '0, 1, 8'h96); chk_rv("t2.k4", 1, 1, 8'hC3, 0, '0);
      tick();
      mid(); chk_rv("t2.k5", 0, 0, '0, 0, '0); chk_rv("t2.k5", 1, 0, '0, 1, 8'h96);
      tick();
      mid(); chk_rv("t2.k6", 1, 0, '0, 0, '0);
      tick();

      // 3: m1 locked write burst of 20 while m0 waits with a single write
      for (int k = 0; k < 16; k++) begin
         drv1(1, 1, 1, 13'(32'h0200 + k), 8'(32'h80 + k));
         drv0(k > 0, 1, 0, 13'h0300, 8'h77);
         mid(); chk_gnt($sformatf("t3.b%0d", k), 0, 1);
         chk_ram($sformatf("t3.b%0d", k), 1, 13'(32'h0200 + k), 8'(32'h80 + k), 0, '0);
         tick();
      end
      drv1(1, 1, 1, 13'h0210, 8'h90);
      mid(); chk_gnt("t3.handover", 1, 0); chk_ram("t3.handover", 1, 13'h0300, 8'h77, 0, '0);
      tick();
      drv0(0, 0, 0, '0, '0);
      for (int k = 16; k < 20; k++) begin
         drv1(1, 1, 1, 13'(32'h0200 + k), 8'(32'h80 + k));
         mid(); chk_gnt($sformatf("t3.b%0d", k), 0, 1);
         chk_ram($sformatf("t3.b%0d", k), 1, 13'(32'h0200 + k), 8'(32'h80 + k), 0, '0);
         tick();
      end
      drv1(0, 0, 0, '0, '0);

      // 4: m0 reads 0x200..0x203 back-to-back
      for (int j = 0; j < 7; j++) begin
         if (j < 4) drv0(1, 0, 0, 13'(32'h0200 + j), '0);
         else       drv0(0, 0, 0, '0, '0);
         mid();
         if (j < 4) begin
            chk_gnt($sformatf("t4.r%0d", j), 1, 0);
            chk_ram($sformatf("t4.r%0d", j), 0, '0, '0, 1, 13'(32'h0200 + j));
         end
         chk_rv($sformatf("t4.c%0d", j), 0, (j >= 1 && j <= 4), 8'(32'h80 + j - 1), 0, '0);
         chk_rv($sformatf("t4.c%0d", j), 1, (j >= 2 && j <= 5), 8'(32'h80 + j - 2), 0, '0);
         tick();
      end

      // 5: reset right after a read accept; m0 must win first contention after
      drv0(1, 0, 0, 13'h0010, '0);
      mid(); chk_gnt("t5.rd", 1, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      drv1(1, 0, 0, 13'h0020, '0);
      #1;
      chk_reset("t5.inrst");
      mid(); chk_reset("t5.inrst2");
      tick();
      rst_n = 1'b1;
      mid(); chk_gnt("t5.k0", 1, 0); chk_ram("t5.k0", 0, '0, '0, 1, 13'h0010);
      chk_rv("t5.k0", 0, 0, '0, 0, '0); chk_rv("t5.k0", 1, 0, '0, 0, '0);
      tick();
      mid(); chk_gnt("t5.k1", 0, 1);
      chk_rv("t5.k1", 0, 1, 8'h3C, 0, '0); chk_rv("t5.k1", 1, 0, '0, 0, '0);
      tick();
      drv0(0, 0, 0, '0, '0); drv1(0, 0, 0, '0, '0);
      mid(); chk_rv("t5.k2", 0, 0, '0, 1, 8'h5A); chk_rv("t5.k2", 1, 1, 8'h3C, 0, '0);
      tick();
      mid(); chk_rv("t5.k3", 0, 0, '0, 0, '0); chk_rv("t5.k3", 1, 0, '0, 1, 8'h5A);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
